mult_operand_loader: RTL and testbench

Upstream operand front-end for the 3-bit shift-and-add multiplier controller. Accepts a multiplier/multiplicand pair over a valid/ready handshake and registers both operands. Presents one multiplier bit per step, LSB first, together with the multiplicand pre-aligned to that bit's weight. The downstream add/accumulate stage consumes each bit by pulsing step; the loader shifts, counts remaining bits and flags the last one.

---
 rtl/mult_operand_loader.sv | 90 +++++++++
 tb/tb_mult_operand_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_operand_loader.sv
// Operand front-end for the shift-and-add multiplier: latches a multiplier/multiplicand
// pair and presents one multiplier bit per step. Define LOADER_EARLY_EXIT_EN to end after the highest set bit.
module mult_operand_loader #(
  parameter  int WIDTH = 3,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_M,
  output logic                 in_ready,
  input  logic                 step,
  output logic                 op_valid,
  output logic                 bit_m,
  output logic [2*WIDTH-1:0]   M_aligned,
  output logic [CW-1:0]        count,
  output logic                 last,
  output logic                 done
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     m_sh_q;
  logic [2*WIDTH-1:0]   mc_sh_q;
  logic [CW-1:0]        count_q;
  logic                 done_q;
  logic                 active;
  logic                 last_d;

  assign active = (state_q == ACTIVE);

  // Gated by active so the cleared registers in IDLE never look like a final bit.
`ifdef LOADER_EARLY_EXIT_EN
  assign last_d = active && ((count_q == CW'(1)) || ((m_sh_q >> 1) == '0));
`else
  assign last_d = active && (count_q == CW'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_sh_q  <= '0;
      mc_sh_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            m_sh_q  <= in_m;
            mc_sh_q <= {{WIDTH{1'b0}}, in_M};
            count_q <= CW'(WIDTH);
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (step) begin
            if (last_d) begin
              m_sh_q  <= '0;
              mc_sh_q <= '0;
              count_q <= '0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              m_sh_q  <= m_sh_q >> 1;
              mc_sh_q <= mc_sh_q << 1;
              count_q <= count_q - CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign op_valid  = active;
  assign bit_m     = m_sh_q[0];
  assign M_aligned = mc_sh_q;
  assign count     = count_q;
  assign last      = last_d;
  assign done      = done_q;

endmodule

// File: tb/tb_mult_operand_loader.sv
// Randomized self-checking bench for mult_operand_loader; the reference model derives each
// operation's bit sequence directly from the operands with plain arithmetic.
module tb_mult_operand_loader;

  localparam int WIDTH = 3;
  localparam int CW    = $clog2(WIDTH + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [WIDTH-1:0]   in_m;
  logic [WIDTH-1:0]   in_M;
  logic               in_ready;
  logic               step;
  logic               op_valid;
  logic               bit_m;
  logic [2*WIDTH-1:0] M_aligned;
  logic [CW-1:0]      count;
  logic               last;
  logic               done;

  int n_tests = 0;
  int n_fail  = 0;

  mult_operand_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_m      (in_m),
    .in_M      (in_M),
    .in_ready  (in_ready),
    .step      (step),
    .op_valid  (op_valid),
    .bit_m     (bit_m),
    .M_aligned (M_aligned),
    .count     (count),
    .last      (last),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Number of bits presented for a given multiplier.
  function automatic int n_steps(input int m);
    int n;
`ifdef LOADER_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < WIDTH; i++)
      if (((m >> i) & 1) == 1) n = i + 1;
`else
    n = WIDTH;
`endif
    return n;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  int'(in_ready),  1);
    check({tag, ".op_valid"},  int'(op_valid),  0);
    check({tag, ".bit_m"},     int'(bit_m),     0);
    check({tag, ".M_aligned"}, int'(M_aligned), 0);
    check({tag, ".count"},     int'(count),     0);
    check({tag, ".last"},      int'(last),      0);
  endtask

  // One complete operation. stall<0 picks a random 0..2 stall per bit.
  // hold_next keeps a new pair on in_valid throughout; preloaded means it was already accepted.
  task automatic run_op(input string name, input int m, input int mc, input int stall,
                        input bit preloaded, input bit hold_next, input int nm, input int nmc);
    int n, sum, st, t;
    string tg;
    n   = n_steps(m);
    sum = 0;
    if (!preloaded) begin
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      check({name, ".wait_ready"}, int'(in_ready), 1);
      in_m     = WIDTH'(m);
      in_M     = WIDTH'(mc);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = hold_next;
    if (hold_next) begin
      in_m = WIDTH'(nm);
      in_M = WIDTH'(nmc);
    end
    for (int i = 0; i < n; i++) begin
      st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int s = 0; s <= st; s++) begin
        tg = $sformatf("%s.b%0d.s%0d", name, i, s);
        check({tg, ".op_valid"},  int'(op_valid),  1);
        check({tg, ".in_ready"},  int'(in_ready),  0);
        check({tg, ".done"},      int'(done),      0);
        check({tg, ".bit_m"},     int'(bit_m),     (m >> i) & 1);
        check({tg, ".M_aligned"}, int'(M_aligned), mc << i);
        check({tg, ".count"},     int'(count),     WIDTH - i);
        check({tg, ".last"},      int'(last),      (i == n - 1) ? 1 : 0);
        if (s == st) begin
          sum += int'(bit_m) * int'(M_aligned);
          step = 1'b1;
        end else begin
          step = 1'b0;
        end
        @(negedge clk);
        step = 1'b0;
      end
    end
    check({name, ".done"},      int'(done),      1);
    check({name, ".op_valid"},  int'(op_valid),  0);
    check({name, ".in_ready"},  int'(in_ready),  1);
    check({name, ".count0"},    int'(count),     0);
    check({name, ".product"},   sum,             m * mc);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, ".done_pulse"}, int'(done), 0);
    $display("[TB] op %s m=%0d M=%0d steps=%0d product=%0d", name, m, mc, n, sum);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_m     = '0;
    in_M     = '0;
    step     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("por");
    check("por.done", int'(done), 0);
    reset = 1'b0;

    // Step in IDLE must be ignored.
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check_idle("idle_step");

    run_op("basic", 5, 3, 0, 1'b0, 1'b0, 0, 0);
    run_op("stall", 5, 3, 4, 1'b0, 1'b0, 0, 0);
    run_op("max",   7, 7, 0, 1'b0, 1'b0, 0, 0);
    run_op("early", 1, 2, 0, 1'b0, 1'b0, 0, 0);
    run_op("zero",  0, 5, 1, 1'b0, 1'b0, 0, 0);

    // New pair offered during an operation is only taken once in_ready returns.
    run_op("hs_a", 6, 5, 1, 1'b0, 1'b1, 3, 4);
    run_op("hs_b", 3, 4, 0, 1'b1, 1'b0, 0, 0);

    // Reset mid-operation, with step asserted, held for 2 cycles.
    in_m = 3'b101; in_M = 3'b011; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    step = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst_mid1");
    check("rst_mid1.done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    step  = 1'b0;
    check_idle("rst_mid2");
    @(negedge clk);
    check_idle("rst_after");
    check("rst_after.done", int'(done), 0);

    // Reset coinciding with the final step suppresses done.
    in_m = 3'b111; in_M = 3'b001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_last.last", int'(last), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step  = 1'b0;
    check("rst_last.done", int'(done), 0);
    check_idle("rst_last");

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check($sformatf("rnd%0d.idle_op_valid", k), int'(op_valid), 0);
      end
      run_op($sformatf("rnd%0d", k), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             -1, 1'b0, 1'b0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
